// File: rtl/neuro_pkg.sv
// rtl/neuro_pkg.sv - shared Q8.8 fixed-point constants and MAC stage state encoding
package neuro_pkg;

    localparam int DATA_W = 16;
    localparam int FRAC_W = 8;

    localparam logic [15:0] Q_ONE = 16'h0100;
    localparam logic [15:0] Q_MAX = 16'h7FFF;
    localparam logic [15:0] Q_MIN = 16'h8000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } mac_state_e;

endpackage

// File: rtl/mac_round_sat.sv
// rtl/mac_round_sat.sv - rounds a wide fixed-point accumulator to DATA_W and saturates it
// Ports:
//   acc    - ACC_W two's-complement accumulator, FRAC_W*2 fractional bits
//   result - DATA_W value with FRAC_W fractional bits, round half toward +inf, clamped
module mac_round_sat #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8,
    parameter int ACC_W  = 40
) (
    input  logic [ACC_W-1:0]  acc,
    output logic [DATA_W-1:0] result
);

    localparam logic [ACC_W-1:0] HALF = ACC_W'(1) << (FRAC_W - 1);

    logic [ACC_W-1:0]      biased;
    logic [ACC_W-1:0]      shifted;
    logic [ACC_W-DATA_W:0] upper;

    always_comb begin
        biased  = acc + HALF;
        shifted = $unsigned($signed(biased) >>> FRAC_W);
        // The value fits in DATA_W only if every bit above the result's sign bit
        // matches that sign bit.
        upper   = shifted[ACC_W-1:DATA_W-1];
        if ((&upper) || (~|upper)) begin
            result = shifted[DATA_W-1:0];
        end else if (upper[ACC_W-DATA_W]) begin
            result = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            result = {1'b0, {(DATA_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/neuron_mac_stage.sv
// rtl/neuron_mac_stage.sv - weighted-sum stage: bias + sum of N x*w products, rounded to Q8.8
// Ports:
//   clk, rst            - clock, asynchronous active-low reset
//   start, dest_in, bias- begin an evaluation (IDLE only); tag and bias latched on start
//   x_in, w_in          - one signed product pair per accepted beat
//   in_valid, in_ready  - input handshake, ready only while accumulating
//   out_val, out_dest   - rounded/saturated sum and its tag, held until replaced
//   out_we              - one-cycle result pulse
//   busy                - evaluation in progress
module neuron_mac_stage #(
    parameter int N_INPUTS = 8,
    parameter int DATA_W   = neuro_pkg::DATA_W,
    parameter int FRAC_W   = neuro_pkg::FRAC_W,
    parameter int ACC_W    = 40
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [15:0]       dest_in,
    input  logic [DATA_W-1:0] bias,
    input  logic [DATA_W-1:0] x_in,
    input  logic [DATA_W-1:0] w_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_val,
    output logic [15:0]       out_dest,
    output logic              out_we,
    output logic              busy
);

    import neuro_pkg::*;

    localparam int CNT_W = $clog2(N_INPUTS + 1);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_ACCUM = ACCUM;
    localparam logic [1:0] ST_ROUND = ROUND;
    localparam logic [1:0] ST_DONE  = DONE;

    logic [1:0]          state;
    logic [ACC_W-1:0]    acc;
    logic [CNT_W-1:0]    count;
    logic [DATA_W-1:0]   outVal;
    logic [15:0]         outDest;

    logic [2*DATA_W-1:0] product;
    logic [ACC_W-1:0]    productExt;
    logic [ACC_W-1:0]    biasExt;
    logic [DATA_W-1:0]   roundedVal;
    logic                beatAccepted;

    always_comb begin
        product    = $signed(x_in) * $signed(w_in);
        productExt = {{(ACC_W-2*DATA_W){product[2*DATA_W-1]}}, product};
        // Bias is Q8.8; the accumulator carries products with 2*FRAC_W fractional
        // bits, so the bias is aligned by shifting it up FRAC_W places.
        biasExt    = {{(ACC_W-DATA_W){bias[DATA_W-1]}}, bias} << FRAC_W;
    end

    assign beatAccepted = (state == ST_ACCUM) && in_valid;

    mac_round_sat #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W),
        .ACC_W  (ACC_W)
    ) u_round_sat (
        .acc    (acc),
        .result (roundedVal)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            acc     <= '0;
            count   <= '0;
            outVal  <= '0;
            outDest <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        outDest <= dest_in;
                        acc     <= biasExt;
                        count   <= '0;
                        state   <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (beatAccepted) begin
                        acc   <= acc + productExt;
                        count <= count + 1'b1;
                        if (count == CNT_W'(N_INPUTS - 1)) begin
                            state <= ST_ROUND;
                        end
                    end
                end
                ST_ROUND: begin
                    outVal <= roundedVal;
                    state  <= ST_DONE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready = (state == ST_ACCUM);
    assign out_we   = (state == ST_DONE);
    assign busy     = (state != ST_IDLE);
    assign out_val  = outVal;
    assign out_dest = outDest;

endmodule
